// File: rtl/text_console_writer.sv
// Write-side engine for the character screen memory: PUT / NEWLINE / CLEAR / HOME with cursor, wrap and scroll.
// Latency: PUT write issued 1 cycle after accept; scroll 2*(NlocC-Ncols)+Ncols cycles; clear NlocC cycles.
// Backpressure: in_ready only in IDLE; commands offered while busy are dropped, never queued.
//
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready - command handshake; in_op/in_char captured on accept
//   smem_*            - second port of the screen memory (registered addr/wr, synchronous read data in)
//   cursor_col/row    - current cursor; busy = !in_ready
module text_console_writer #(
    parameter int Ncols  = 40,
    parameter int Nrows  = 30,
    parameter int NlocC  = 1200,
    parameter int DbitsC = 4,
    parameter int BLANK  = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [DbitsC-1:0]        in_char,
    output logic [$clog2(NlocC)-1:0] smem_addr,
    output logic                     smem_wr,
    output logic [DbitsC-1:0]        smem_wdata,
    input  logic [DbitsC-1:0]        smem_rdata,
    output logic [$clog2(Ncols)-1:0] cursor_col,
    output logic [$clog2(Nrows)-1:0] cursor_row,
    output logic                     busy
);

    localparam int AW = $clog2(NlocC);
    localparam int CW = $clog2(Ncols);
    localparam int RW = $clog2(Nrows);

    localparam logic [AW-1:0]     NCOLS_A    = AW'(Ncols);
    localparam logic [AW-1:0]     LAST_SRC   = AW'(NlocC - Ncols - 1);
    localparam logic [AW-1:0]     FILL_START = AW'(NlocC - Ncols);
    localparam logic [AW-1:0]     LAST_ADDR  = AW'(NlocC - 1);
    localparam logic [CW-1:0]     COL_LAST   = CW'(Ncols - 1);
    localparam logic [RW-1:0]     ROW_LAST   = RW'(Nrows - 1);
    localparam logic [DbitsC-1:0] BLANK_D    = DbitsC'(BLANK);

    localparam logic [1:0] OP_PUT   = 2'b00;
    localparam logic [1:0] OP_NL    = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_HOME  = 2'b11;

    typedef enum logic [2:0] {IDLE, PUT, SC_RD, SC_WR, SC_CLR, CLR} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DbitsC-1:0] wdata_q, wdata_d;

    logic [AW-1:0]     row_base;
    logic [AW-1:0]     cur_addr;

    // row*Ncols: two shifts and an add for the 40-column screen.
    if (Ncols == 40) begin : g_row_shift
        assign row_base = (AW'(row_q) << 5) + (AW'(row_q) << 3);
    end else begin : g_row_mul
        assign row_base = AW'(row_q) * NCOLS_A;
    end

    assign cur_addr = row_base + AW'(col_q);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    case (in_op)
                        OP_PUT: begin
                            state_d = PUT;
                            addr_d  = cur_addr;
                            wdata_d = in_char;
                            wr_d    = 1'b1;
                        end
                        OP_NL: begin
                            col_d = '0;
                            if (row_q != ROW_LAST) begin
                                row_d = row_q + RW'(1);
                            end else begin
                                state_d = SC_RD;
                                cnt_d   = '0;
                                addr_d  = NCOLS_A;
                            end
                        end
                        OP_CLEAR: begin
                            state_d = CLR;
                            cnt_d   = '0;
                            addr_d  = '0;
                            wdata_d = BLANK_D;
                            wr_d    = 1'b1;
                        end
                        OP_HOME: begin
                            col_d = '0;
                            row_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            PUT: begin
                state_d = IDLE;
                if (col_q != COL_LAST) begin
                    col_d = col_q + CW'(1);
                end else if (row_q != ROW_LAST) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    // Cursor is left alone until the scroll finishes.
                    state_d = SC_RD;
                    cnt_d   = '0;
                    addr_d  = NCOLS_A;
                end
            end
            SC_RD: begin
                state_d = SC_WR;
                addr_d  = cnt_q;
                wr_d    = 1'b1;
            end
            SC_WR: begin
                if (cnt_q == LAST_SRC) begin
                    state_d = SC_CLR;
                    cnt_d   = FILL_START;
                    addr_d  = FILL_START;
                    wdata_d = BLANK_D;
                    wr_d    = 1'b1;
                end else begin
                    state_d = SC_RD;
                    cnt_d   = cnt_q + AW'(1);
                    addr_d  = cnt_q + NCOLS_A + AW'(1);
                end
            end
            SC_CLR, CLR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    col_d   = '0;
                    row_d   = (state_q == SC_CLR) ? ROW_LAST : '0;
                end else begin
                    cnt_d  = cnt_q + AW'(1);
                    addr_d = cnt_q + AW'(1);
                    wr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    // The read issued in SC_RD only returns during SC_WR, so the scroll copy
    // forwards the read data straight to the write port in that state.
    assign smem_wdata = (state_q == SC_WR) ? smem_rdata : wdata_q;
    assign smem_addr  = addr_q;
    assign smem_wr    = wr_q;
    assign in_ready   = (state_q == IDLE);
    assign busy       = ~in_ready;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a synchronous-read screen memory model.
// Latency: n/a (testbench).
// Backpressure: commands are offered only after in_ready is seen high.
module tb_text_console_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [3:0]  in_char;
    logic [10:0] smem_addr;
    logic        smem_wr;
    logic [3:0]  smem_wdata;
    logic [3:0]  smem_rdata;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    localparam logic [1:0] OP_PUT = 2'b00, OP_NL = 2'b01, OP_CLEAR = 2'b10, OP_HOME = 2'b11;

    always #5 clock = ~clock;

    text_console_writer dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_char    (in_char),
        .smem_addr  (smem_addr),
        .smem_wr    (smem_wr),
        .smem_wdata (smem_wdata),
        .smem_rdata (smem_rdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    // Screen memory port 2: synchronous read, write on the same edge.
    logic [3:0] mem [0:1199];
    always @(posedge clock) begin
        if (smem_wr === 1'b1 && smem_addr < 11'd1200) mem[smem_addr] <= smem_wdata;
        if (smem_addr < 11'd1200) smem_rdata <= mem[smem_addr];
    end

    // Write log, sampled just after each rising edge.
    int cyc = 0;
    int oob = 0;
    int wr_a[$];
    int wr_d[$];
    int wr_t[$];
    always @(posedge clock) begin
        cyc = cyc + 1;
        #1;
        if (smem_wr === 1'b1) begin
            wr_a.push_back(int'(smem_addr));
            wr_d.push_back(int'(smem_wdata));
            wr_t.push_back(cyc);
            if (smem_addr >= 11'd1200) oob++;
        end
    end

    int checks = 0;
    int errors = 0;
    int last_busy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_a.delete();
        wr_d.delete();
        wr_t.delete();
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] ch);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 5000) chk("ready_timeout", n, 0);
        in_valid = 1'b1;
        in_op    = op;
        in_char  = ch;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        last_busy = 0;
        while (busy !== 1'b0 && last_busy < 5000) begin
            @(negedge clock);
            last_busy++;
        end
        if (busy !== 1'b0) chk("idle_timeout", last_busy, 0);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] ch);
        send(op, ch);
        wait_idle();
    endtask

    initial begin
        int bad;
        int e;
        int exp_rdy [5];
        exp_rdy = '{0, 1, 0, 1, 0};

        reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_char = 4'd0;
        for (int a = 0; a < 1200; a++) mem[a] = 4'd0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr", smem_wr, 0);
        chk("rst_addr", smem_addr, 0);
        chk("rst_wdata", smem_wdata, 0);
        chk("rst_col", cursor_col, 0);
        chk("rst_row", cursor_row, 0);
        reset = 1'b0;

        // Three back-to-back PUTs of code 5 with valid held high.
        clear_log();
        in_valid = 1'b1; in_op = OP_PUT; in_char = 4'd5;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            @(negedge clock);
            chk("put3_ready", in_ready, exp_rdy[k]);
            if (k == 4) in_valid = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
        chk("put3_count", wr_a.size(), 3);
        if (wr_a.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("put3_addr", wr_a[k], k);
                chk("put3_data", wr_d[k], 5);
            end
            chk("put3_gap", wr_t[2] - wr_t[1], 2);
        end
        chk("put3_col", cursor_col, 3);
        chk("put3_row", cursor_row, 0);

        // 40 PUTs wrap to the next row.
        cmd(OP_HOME, 4'd0);
        clear_log();
        for (int k = 0; k < 40; k++) cmd(OP_PUT, 4'd7);
        chk("put_busy", last_busy, 1);
        chk("put40_count", wr_a.size(), 40);
        bad = 0;
        for (int k = 0; k < wr_a.size(); k++) if (wr_a[k] != k || wr_d[k] != 7) bad++;
        chk("put40_bad", bad, 0);
        chk("put40_col", cursor_col, 0);
        chk("put40_row", cursor_row, 1);

        // NEWLINE from (12,5).
        for (int k = 0; k < 4; k++) cmd(OP_NL, 4'd0);
        for (int k = 0; k < 12; k++) cmd(OP_PUT, 4'd2);
        chk("pos12_5_col", cursor_col, 12);
        chk("pos12_5_row", cursor_row, 5);
        clear_log();
        send(OP_NL, 4'd0);
        chk("nl_ready", in_ready, 1);
        chk("nl_col", cursor_col, 0);
        chk("nl_row", cursor_row, 6);
        @(negedge clock);
        chk("nl_nowrite", wr_a.size(), 0);

        // NEWLINE on the last row scrolls a preloaded screen.
        cmd(OP_HOME, 4'd0);
        for (int k = 0; k < 29; k++) cmd(OP_NL, 4'd0);
        chk("nl29_row", cursor_row, 29);
        for (int a = 0; a < 1200; a++) begin
            e = a % 16;
            mem[a] = e[3:0];
        end
        send(OP_NL, 4'd0);
        wait_idle();
        chk("scroll_busy", last_busy, 2360);
        bad = 0;
        for (int a = 0; a < 1200; a++) begin
            e = (a < 1160) ? (a + 40) % 16 : 0;
            if (mem[a] !== e[3:0]) bad++;
        end
        chk("scroll_mem_bad", bad, 0);
        chk("scroll_col", cursor_col, 0);
        chk("scroll_row", cursor_row, 29);

        // PUT at the bottom-right corner, then scroll.
        for (int k = 0; k < 39; k++) cmd(OP_PUT, 4'd1);
        chk("corner_col", cursor_col, 39);
        chk("corner_row", cursor_row, 29);
        clear_log();
        send(OP_PUT, 4'd9);
        wait_idle();
        chk("corner_busy", last_busy, 2361);
        chk("corner_count", wr_a.size(), 1201);
        if (wr_a.size() > 0) begin
            chk("corner_addr", wr_a[0], 1199);
            chk("corner_data", wr_d[0], 9);
        end
        chk("corner_mem1159", mem[1159], 9);
        bad = 0;
        for (int a = 0; a < 1200; a++) begin
            if (a < 1120)      e = (a + 80) % 16;
            else if (a < 1159) e = 1;
            else if (a == 1159) e = 9;
            else               e = 0;
            if (mem[a] !== e[3:0]) bad++;
        end
        chk("corner_mem_bad", bad, 0);
        chk("corner_col2", cursor_col, 0);
        chk("corner_row2", cursor_row, 29);

        // CLEAR from (17,8) with a stray command mid-clear.
        cmd(OP_HOME, 4'd0);
        for (int k = 0; k < 8; k++) cmd(OP_NL, 4'd0);
        for (int k = 0; k < 17; k++) cmd(OP_PUT, 4'd3);
        chk("pos17_8_col", cursor_col, 17);
        chk("pos17_8_row", cursor_row, 8);
        clear_log();
        send(OP_CLEAR, 4'd0);
        repeat (600) @(negedge clock);
        in_valid = 1'b1; in_op = OP_PUT; in_char = 4'd15;
        @(negedge clock);
        in_valid = 1'b0;
        wait_idle();
        chk("clear_busy", last_busy + 601, 1200);
        repeat (3) @(negedge clock);
        chk("clear_count", wr_a.size(), 1200);
        bad = 0;
        for (int k = 0; k < wr_a.size(); k++) if (wr_a[k] != k || wr_d[k] != 0) bad++;
        chk("clear_seq_bad", bad, 0);
        bad = 0;
        for (int a = 0; a < 1200; a++) if (mem[a] !== 4'd0) bad++;
        chk("clear_mem_bad", bad, 0);
        chk("clear_col", cursor_col, 0);
        chk("clear_row", cursor_row, 0);

        // HOME from (5,5).
        for (int k = 0; k < 5; k++) cmd(OP_NL, 4'd0);
        for (int k = 0; k < 5; k++) cmd(OP_PUT, 4'd4);
        chk("pos5_5_col", cursor_col, 5);
        chk("pos5_5_row", cursor_row, 5);
        send(OP_HOME, 4'd0);
        chk("home_ready", in_ready, 1);
        chk("home_col", cursor_col, 0);
        chk("home_row", cursor_row, 0);

        // Reset in the middle of a scroll.
        for (int k = 0; k < 29; k++) cmd(OP_NL, 4'd0);
        send(OP_NL, 4'd0);
        repeat (499) @(negedge clock);
        chk("midscroll_busy", busy, 1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("abort_ready", in_ready, 1);
        chk("abort_wr", smem_wr, 0);
        chk("abort_addr", smem_addr, 0);
        chk("abort_col", cursor_col, 0);
        chk("abort_row", cursor_row, 0);
        clear_log();
        cmd(OP_PUT, 4'd11);
        chk("abort_put_count", wr_a.size(), 1);
        if (wr_a.size() == 1) begin
            chk("abort_put_addr", wr_a[0], 0);
            chk("abort_put_data", wr_d[0], 11);
        end

        chk("addr_range", oob, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Write-side engine for the 40x30 character screen memory that the VGA display driver reads.
- Accepts character and control commands over a valid/ready handshake and writes character codes into the screen memory's second port at row*Ncols+col.
- Maintains a cursor, wraps at line end, scrolls the screen up one row when the cursor passes the last row, and clears the screen on command.

Parameters:
Ncols, 40, characters per row
Nrows, 30, rows per screen
NlocC, 1200, screen memory locations; must equal Ncols*Nrows
DbitsC, 4, character code width
BLANK, 0, character code written by clear and scroll-fill

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  command present
in_ready  output  1  engine accepts command this cycle; equals (state==IDLE)
in_op  input  2  00 PUT, 01 NEWLINE, 10 CLEAR, 11 HOME
in_char  input  DbitsC  character code for PUT; ignored otherwise
smem_addr  output  $clog2(NlocC)  screen memory address
smem_wr  output  1  write enable
smem_wdata  output  DbitsC  write data
smem_rdata  input  DbitsC  read data, valid one cycle after smem_addr (synchronous read)
cursor_col  output  $clog2(Ncols)  current column
cursor_row  output  $clog2(Nrows)  current row
busy  output  1  equals !in_ready

Behaviour:
- Reset (sampled high at an edge): state=IDLE, cursor (0,0), smem_wr=0, smem_addr=0, smem_wdata=0, scroll/clear counters=0. Reset aborts any operation immediately; partial memory contents are left as they are.
- Accept: a command is taken at an edge where in_valid && in_ready. in_op/in_char are captured then and need not be held afterwards.
- States: IDLE, PUT, SC_RD, SC_WR, SC_CLR, CLR.
- Outputs smem_addr, smem_wr and smem_wdata are registered. smem_wr is 1 only in PUT, SC_WR, SC_CLR and CLR. When not writing, smem_addr holds its last value and smem_wdata is don't-care.
- PUT:
  - Accept -> PUT for 1 cycle: smem_addr=row*Ncols+col, smem_wdata=char, smem_wr=1.
  - Cursor advance at exit:
    - if col<Ncols-1, col+1;
    - else col=0 and row+1 if row<Nrows-1;
    - else scroll.
  - Exit to IDLE, or to SC_RD when a scroll is needed. Sustained throughput is 1 PUT per 2 cycles.
- NEWLINE: at the accept edge col=0; row+1 if row<Nrows-1, else go to SC_RD. No memory write.
- HOME: at the accept edge cursor=(0,0); stay IDLE. No memory write.
- CLEAR:
  - Accept -> CLR, writing BLANK to addresses 0..NlocC-1, one per cycle, ascending (1200 cycles).
  - Then cursor=(0,0) and IDLE.
- Scroll (i from 0 to NlocC-Ncols-1):
  - SC_RD: smem_addr=i+Ncols, smem_wr=0.
  - SC_WR: smem_addr=i, smem_wdata=smem_rdata, smem_wr=1.
  - After i=NlocC-Ncols-1, go to SC_CLR: write BLANK to NlocC-Ncols..NlocC-1, one per cycle.
  - Then IDLE with cursor (0, Nrows-1).
  - Duration: 2*(NlocC-Ncols)+Ncols = 2360 cycles at the defaults.
- Address arithmetic:
  - Addresses are $clog2(NlocC) bits wide.
  - row*Ncols is computed as (row<<5)+(row<<3) when Ncols=40, or a generic constant multiply otherwise.
  - No address may exceed NlocC-1.
- Simultaneous events: reset has priority over everything. in_valid during busy is ignored and is not queued. The cursor outputs are stable during CLR and scroll, and show the final value from the cycle IDLE is re-entered.
- The display port reads concurrently; there is no arbitration, and transient tearing during scroll or clear is acceptable.

Test Plan:
- Reset, then PUT code 5 three times back-to-back with valid held high -> writes (addr,data) (0,5),(1,5),(2,5) on alternate cycles; cursor (3,0); in_ready toggles 1,0,1,0.
- 40 PUTs of code 7 from (0,0) -> addresses 0..39 written; cursor (0,1). NEWLINE at (12,5) -> cursor (0,6), no smem_wr pulse.
- Preload memory[a]=a%16, cursor (0,29), NEWLINE -> busy exactly 2360 cycles; afterwards mem[a]=(a+40)%16 for a<1160 and mem[1160..1199]=0; cursor (0,29).
- PUT code 9 at (39,29) -> addr 1199 written with 9, then scroll; afterwards mem[1159]=9, last row BLANK, cursor (0,29).
- CLEAR from cursor (17,8) -> 1200 consecutive writes of 0 to 0..1199; cursor (0,0); in_valid pulsed mid-clear is not accepted. HOME from (5,5) -> (0,0) in 1 cycle.
- Assert reset for 1 cycle at scroll cycle 500 -> next cycle state IDLE, in_ready=1, smem_wr=0, cursor (0,0); an immediate PUT writes addr 0.
